exc_ctrl: RTL and testbench

//  Exception/interrupt sequencer in front of the CP0 register file.

---
 rtl/exc_ctrl_pkg.sv | 16 +
 rtl/exc_ctrl_prio.sv | 20 ++
 rtl/exc_ctrl.sv | 80 ++++++++
 tb/tb_exc_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/exc_ctrl_pkg.sv
// exc_ctrl_pkg: shared exception codes, state encodings and Status bit positions
package exc_ctrl_pkg;
    localparam logic [31:0] EXC_INT     = 32'h0000_0004;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0100;
    localparam logic [31:0] EXC_ERET    = 32'h0000_0200;
    localparam int SR_IE     = 0;
    localparam int SR_EXL    = 1;
    localparam int SR_IM_HI  = 15;
    localparam int SR_IM_LO  = 8;
    localparam int SR_IM_TMR = 10;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ENTER = 2'd1, S_FLUSH = 2'd2} state_t;
    typedef enum logic [1:0] {W_NONE = 2'd0, W_INT = 2'd1, W_SYS = 2'd2, W_ERET = 2'd3} win_t;
    function automatic logic [31:0] exc_code(input win_t w);
        return w == W_INT ? EXC_INT : w == W_SYS ? EXC_SYSCALL : w == W_ERET ? EXC_ERET : 32'h0;
    endfunction
endpackage

// File: rtl/exc_ctrl_prio.sv
// exc_prio: masks pending interrupts against Status and picks int > syscall > eret
module exc_prio
    import exc_ctrl_pkg::*;
(
    input  logic [31:0] status,
    input  logic [31:0] cause,
    input  logic        intimer,
    input  logic        is_syscall,
    input  logic        is_eret,
    output win_t        win,
    output logic        req
);
    logic int_pend;
    logic unused;
    assign unused = ^{status[31:16], status[7:2], cause[31:16], cause[7:0]};
    assign int_pend = status[SR_IE] & ~status[SR_EXL] &
                      ((|(cause[SR_IM_HI:SR_IM_LO] & status[SR_IM_HI:SR_IM_LO])) | (intimer & status[SR_IM_TMR]));
    assign win = int_pend ? W_INT : is_syscall ? W_SYS : is_eret ? W_ERET : W_NONE;
    assign req = int_pend | is_syscall | is_eret;
endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: sequences one CP0 exception pulse, a timed flush and a fetch redirect
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] HANDLER_VEC  = 32'h0000_0040,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    input  logic [31:0] inst_pc,
    input  logic        is_syscall,
    input  logic        is_eret,
    input  logic        intimer,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    output logic [31:0] excptype,
    output logic [31:0] excpc,
    output logic        flush,
    output logic        new_pc_valid,
    output logic [31:0] new_pc,
    output logic        busy
);
    state_t     state;
    win_t       kind;
    win_t       win;
    logic       req;
    logic [3:0] cnt;
    exc_prio u_prio (
        .status     (status_i),
        .cause      (cause_i),
        .intimer    (intimer),
        .is_syscall (is_syscall),
        .is_eret    (is_eret),
        .win        (win),
        .req        (req)
    );
    // eret target is read live so the redirect sees EPC as CP0 holds it in the first flush cycle
    assign new_pc = !new_pc_valid ? 32'h0 : kind == W_ERET ? epc_i : HANDLER_VEC;
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            kind         <= W_NONE;
            cnt          <= '0;
            excptype     <= '0;
            excpc        <= '0;
            flush        <= 1'b0;
            new_pc_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (inst_valid && req) begin
                    state    <= S_ENTER;
                    kind     <= win;
                    excptype <= exc_code(win);
                    excpc    <= inst_pc;
                    busy     <= 1'b1;
                end
                S_ENTER: begin
                    state        <= S_FLUSH;
                    excptype     <= '0;
                    excpc        <= '0;
                    flush        <= 1'b1;
                    new_pc_valid <= 1'b1;
                    cnt          <= 4'(FLUSH_CYCLES - 1);
                end
                S_FLUSH: begin
                    new_pc_valid <= 1'b0;
                    if (cnt == 4'd0) begin
                        state <= S_IDLE;
                        flush <= 1'b0;
                        busy  <= 1'b0;
                    end else cnt <= cnt - 4'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: scoreboard bench; stimulus pushes expected CP0 pulses, redirects and flush lengths
module tb_exc_ctrl;
    logic        clk = 1'b0;
    logic        rst, inst_valid, is_syscall, is_eret, intimer;
    logic [31:0] inst_pc, status_i, cause_i, epc_i;
    logic [31:0] excptype, excpc, new_pc;
    logic        flush, new_pc_valid, busy;
    int          checks = 0, failures = 0, ent_count = 0, run = 0, ent0;
    logic [63:0] eq[$];
    logic [31:0] rq[$];
    int          fq[$];
    logic [63:0] e;
    logic [31:0] r;
    int          f;
    exc_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .inst_valid   (inst_valid),
        .inst_pc      (inst_pc),
        .is_syscall   (is_syscall),
        .is_eret      (is_eret),
        .intimer      (intimer),
        .status_i     (status_i),
        .cause_i      (cause_i),
        .epc_i        (epc_i),
        .excptype     (excptype),
        .excpc        (excpc),
        .flush        (flush),
        .new_pc_valid (new_pc_valid),
        .new_pc       (new_pc),
        .busy         (busy)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask
    always @(negedge clk) begin
        if (excptype != 32'h0) begin
            ent_count++;
            if (eq.size() == 0) chk("enter_unexpected", {excptype, excpc}, 64'h0);
            else begin
                e = eq.pop_front();
                chk("enter_type_pc", {excptype, excpc}, e);
            end
        end
        if (new_pc_valid) begin
            if (rq.size() == 0) chk("redirect_unexpected", {32'h0, new_pc}, 64'h0);
            else begin
                r = rq.pop_front();
                chk("redirect_pc", {32'h0, new_pc}, {32'h0, r});
            end
        end
        if (flush) run++;
        else if (run > 0) begin
            f = (fq.size() == 0) ? 0 : fq.pop_front();
            chk("flush_len", 64'(run), 64'(f));
            run = 0;
        end
    end
    task automatic issue(input logic [31:0] st, input logic ti, input logic sy, input logic er,
                         input logic [31:0] pc, input logic [31:0] ep);
        status_i = st; intimer = ti; is_syscall = sy; is_eret = er; inst_pc = pc; epc_i = ep;
        inst_valid = 1'b1;
        @(posedge clk); #1;
        inst_valid = 1'b0; is_syscall = 1'b0; is_eret = 1'b0;
    endtask
    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk); #1;
            if (!busy) done = 1;
        end
        if (!done) chk("idle_timeout", 64'(busy), 64'h0);
    endtask
    task automatic chk_zero(input string nm);
        chk({nm, "_excptype"}, 64'(excptype), 64'h0);
        chk({nm, "_excpc"}, 64'(excpc), 64'h0);
        chk({nm, "_outs"}, {60'h0, flush, new_pc_valid, busy, |new_pc}, 64'h0);
    endtask
    initial begin
        rst = 1'b1; inst_valid = 1'b0; is_syscall = 1'b0; is_eret = 1'b0; intimer = 1'b0;
        inst_pc = '0; status_i = '0; cause_i = '0; epc_i = '0;
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        rst = 1'b0;
        // sequence aborted by reset during the first flush cycle
        eq.push_back({32'h100, 32'h500}); rq.push_back(32'h40); fq.push_back(1);
        issue(32'h1, 1'b0, 1'b1, 1'b0, 32'h500, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_zero("reset_mid_flush");
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1 chk("abort_enter_count", 64'(ent_count), 64'd1);
        // timer interrupt
        eq.push_back({32'h4, 32'h100}); rq.push_back(32'h40); fq.push_back(2);
        issue(32'h401, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
        wait_idle(); intimer = 1'b0; repeat (2) @(posedge clk);
        // syscall
        eq.push_back({32'h100, 32'h200}); rq.push_back(32'h40); fq.push_back(2);
        issue(32'h1, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0);
        wait_idle(); repeat (2) @(posedge clk);
        // eret with EXL set masks the pending timer interrupt
        eq.push_back({32'h200, 32'h208}); rq.push_back(32'h204); fq.push_back(2);
        issue(32'h3, 1'b1, 1'b0, 1'b1, 32'h208, 32'h204);
        wait_idle(); intimer = 1'b0; repeat (2) @(posedge clk);
        // interrupt beats simultaneous syscall
        eq.push_back({32'h4, 32'h300}); rq.push_back(32'h40); fq.push_back(2);
        issue(32'h401, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0);
        wait_idle(); intimer = 1'b0; repeat (2) @(posedge clk);
        // second syscall held upstream while busy
        ent0 = ent_count;
        eq.push_back({32'h100, 32'h400}); eq.push_back({32'h100, 32'h404});
        rq.push_back(32'h40); rq.push_back(32'h40); fq.push_back(2); fq.push_back(2);
        status_i = 32'h1; is_syscall = 1'b1; inst_pc = 32'h400; inst_valid = 1'b1;
        @(posedge clk); #1;
        inst_pc = 32'h404;
        wait_idle();
        @(posedge clk); #1;
        chk("held_accept_busy", 64'(busy), 64'h1);
        inst_valid = 1'b0; is_syscall = 1'b0;
        wait_idle(); repeat (3) @(posedge clk);
        #1 chk("held_enter_count", 64'(ent_count - ent0), 64'd2);
        chk("eq_drained", 64'(eq.size()), 64'h0);
        chk("rq_drained", 64'(rq.size()), 64'h0);
        chk("fq_drained", 64'(fq.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
